// File: rtl/ptw_multi.sv
// Multi-channel page-table-walker test stub: round-robin arbitration, fixed-latency
// one-hot response with a deterministic VPN+offset mapping. Define PTW_FAULT_EN to enable page faults.
module ptw_multi #(
    parameter int NUM_CH     = 2,
    parameter int VA_WIDTH   = 32,
    parameter int PAGE_BITS  = 12,
    parameter int PPN_WIDTH  = 20,
    parameter int LATENCY    = 8,
    parameter int PPN_OFFSET = 4,
    parameter     VPN_LIMIT  = 20'h80000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH*VA_WIDTH-1:0] req_va,
    input  logic                       flush,
    output logic [NUM_CH-1:0]          resp_valid,
    output logic [PPN_WIDTH-1:0]       resp_ppn,
    output logic                       resp_fault,
    output logic                       busy
);

    localparam int VPN_W = VA_WIDTH - PAGE_BITS;
    localparam int EXT_W = VPN_W + PPN_WIDTH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, WALK} state_t;

    state_t                 state, state_next;
    logic [CH_W-1:0]        ptr, grant, ch;
    logic                   grant_any, accept;
    logic [VPN_W-1:0]       grant_vpn, vpn;
    logic [CNT_W-1:0]       cnt;

    // Zero-extend (or truncate) the VPN to PPN width, then add the test offset modulo 2^PPN_WIDTH.
    function automatic logic [PPN_WIDTH-1:0] map_ppn(input logic [VPN_W-1:0] v);
        logic [EXT_W-1:0] ext;
        ext = EXT_W'(v);
        return ext[PPN_WIDTH-1:0] + PPN_WIDTH'(PPN_OFFSET);
    endfunction

    function automatic logic vpn_faults(input logic [VPN_W-1:0] v);
        return EXT_W'(v) >= EXT_W'(VPN_LIMIT);
    endfunction

    // Round-robin search: iterate downward so the channel closest to ptr is the last (winning) write.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant     = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant     = CH_W'(idx);
            end
        end
        grant_vpn = req_va[int'(grant)*VA_WIDTH + PAGE_BITS +: VPN_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (!flush && grant_any) begin
                    req_ready[grant] = 1'b1;
                    state_next       = WALK;
                end
            end
            WALK: begin
                if (flush || cnt == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = |(req_valid & req_ready);
    assign busy   = (state == WALK);

`ifdef PTW_FAULT_EN
    logic fault_r;
    assign resp_fault = fault_r;
`else
    assign resp_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            ch         <= '0;
            vpn        <= '0;
            cnt        <= '0;
            resp_valid <= '0;
            resp_ppn   <= '0;
`ifdef PTW_FAULT_EN
            fault_r    <= 1'b0;
`endif
        end else begin
            resp_valid <= '0;
            if (state == IDLE) begin
                if (accept) begin
                    vpn <= grant_vpn;
                    ch  <= grant;
                    cnt <= CNT_W'(LATENCY - 1);
                    ptr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                end
            end else if (!flush) begin
                // Flush drops the walk outright, even on the completing edge.
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    resp_valid <= NUM_CH'(1) << ch;
`ifdef PTW_FAULT_EN
                    fault_r    <= vpn_faults(vpn);
                    resp_ppn   <= vpn_faults(vpn) ? '0 : map_ppn(vpn);
`else
                    resp_ppn   <= map_ppn(vpn);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ptw_multi.sv
// Directed self-checking bench for ptw_multi (default parameters, NUM_CH=2, LATENCY=8).
module tb_ptw_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_va = '0;
    logic        flush = 1'b0;
    logic [1:0]  resp_valid;
    logic [19:0] resp_ppn;
    logic        resp_fault;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ptw_multi #(
        .NUM_CH(2), .VA_WIDTH(32), .PAGE_BITS(12), .PPN_WIDTH(20),
        .LATENCY(8), .PPN_OFFSET(4), .VPN_LIMIT(20'h80000)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_va(req_va), .flush(flush), .resp_valid(resp_valid),
        .resp_ppn(resp_ppn), .resp_fault(resp_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Raise a request, wait (bounded) for acceptance, return at the negedge after the accept edge.
    task automatic issue(input int c, input logic [31:0] va);
        bit got;
        got = 1'b0;
        req_valid[c] = 1'b1;
        req_va[c*32 +: 32] = va;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req_ready[c]) got = 1'b1;
            @(negedge clk);
        end
        req_valid[c] = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL issue_timeout ch%0d: req_ready never asserted, required grant", c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, resp_ppn, resp_fault, busy} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b ppn=%h f=%b busy=%b, required all 0",
                     req_ready, resp_valid, resp_ppn, resp_fault, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        issue(0, 32'h0001_2345);
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            n_checks++;
            if (resp_valid !== ((k == 9) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL single_resp_valid k=%0d: got %b required %b", k, resp_valid, (k == 9) ? 2'b01 : 2'b00);
            end
            n_checks++;
            if (busy !== (k <= 8)) begin
                n_fail++;
                $display("FAIL single_busy k=%0d: got %b required %b", k, busy, (k <= 8));
            end
            if (k == 9) begin
                n_checks++;
                if (resp_ppn !== 20'h00016 || resp_fault !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_ppn: got %h/%b required 00016/0", resp_ppn, resp_fault);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_va = {32'h0000_2000, 32'h0000_1000};
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL arb_first_grant: got %b required 01", req_ready);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 10) req_valid[1] = 1'b0;
            n_checks++;
            if (resp_valid !== ((k == 9) ? 2'b01 : (k == 18) ? 2'b10 : 2'b00)) begin
                n_fail++;
                $display("FAIL arb_resp_valid k=%0d: got %b", k, resp_valid);
            end
            if (k == 9) begin
                n_checks++;
                if (resp_ppn !== 20'h00005 || req_ready !== 2'b10) begin
                    n_fail++;
                    $display("FAIL arb_ch0_resp: got ppn=%h rdy=%b required 00005/10", resp_ppn, req_ready);
                end
            end
            if (k == 18) begin
                n_checks++;
                if (resp_ppn !== 20'h00006) begin
                    n_fail++;
                    $display("FAIL arb_ch1_ppn: got %h required 00006", resp_ppn);
                end
            end
        end
    endtask

    task automatic test_fault_wrap();
        logic [19:0] exp_ppn;
        logic        exp_fault;
`ifdef PTW_FAULT_EN
        exp_ppn = 20'h00000; exp_fault = 1'b1;
`else
        exp_ppn = 20'h80004; exp_fault = 1'b0;
`endif
        issue(1, 32'h8000_0000);
        repeat (8) @(negedge clk);
        n_checks++;
        if (resp_valid !== 2'b10 || resp_ppn !== exp_ppn || resp_fault !== exp_fault) begin
            n_fail++;
            $display("FAIL fault_limit: got rv=%b ppn=%h f=%b required 10/%h/%b",
                     resp_valid, resp_ppn, resp_fault, exp_ppn, exp_fault);
        end
`ifdef PTW_FAULT_EN
        exp_ppn = 20'h00000; exp_fault = 1'b1;
`else
        exp_ppn = 20'h00003; exp_fault = 1'b0;
`endif
        issue(0, 32'hFFFF_F000);
        repeat (8) @(negedge clk);
        n_checks++;
        if (resp_valid !== 2'b01 || resp_ppn !== exp_ppn || resp_fault !== exp_fault) begin
            n_fail++;
            $display("FAIL wrap: got rv=%b ppn=%h f=%b required 01/%h/%b",
                     resp_valid, resp_ppn, resp_fault, exp_ppn, exp_fault);
        end
    endtask

    task automatic test_flush_mid();
        issue(0, 32'h0000_3000);
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 3) flush = 1'b1;
            if (k == 4) begin
                flush = 1'b0;
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_busy: got %b required 0", busy);
                end
                req_va[32 +: 32] = 32'h0000_5000;
                req_valid[1] = 1'b1;
                #1;
                n_checks++;
                if (req_ready !== 2'b10) begin
                    n_fail++;
                    $display("FAIL flush_reaccept: got %b required 10", req_ready);
                end
            end
            if (k == 5) req_valid[1] = 1'b0;
            n_checks++;
            if (resp_valid !== ((k == 13) ? 2'b10 : 2'b00)) begin
                n_fail++;
                $display("FAIL flush_resp_valid k=%0d: got %b", k, resp_valid);
            end
            if (k == 13) begin
                n_checks++;
                if (resp_ppn !== 20'h00009) begin
                    n_fail++;
                    $display("FAIL flush_new_ppn: got %h required 00009", resp_ppn);
                end
            end
        end
    endtask

    task automatic test_flush_completion();
        issue(0, 32'h0000_7000);
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 8) flush = 1'b1;
            if (k == 9) begin
                flush = 1'b0;
                n_checks++;
                if (busy !== 1'b0 || resp_ppn !== 20'h00009) begin
                    n_fail++;
                    $display("FAIL flushcmp_state: got busy=%b ppn=%h required 0/00009", busy, resp_ppn);
                end
            end
            if (k == 10) begin
                req_valid[1] = 1'b1;
                #1;
                n_checks++;
                if (req_ready !== 2'b10) begin
                    n_fail++;
                    $display("FAIL flushcmp_idle: got rdy=%b required 10", req_ready);
                end
                req_valid[1] = 1'b0;
            end
            n_checks++;
            if (resp_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL flushcmp_resp k=%0d: got %b required 00", k, resp_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(0, 32'h0000_1000);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, resp_valid, resp_ppn, resp_fault, busy} !== 26'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got rdy=%b rv=%b ppn=%h f=%b busy=%b, required all 0",
                     req_ready, resp_valid, resp_ppn, resp_fault, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 2'b00) begin
                n_fail++;
                $display("FAIL rstmid_resp k=%0d: got %b required 00", k, resp_valid);
            end
        end
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_ptr: got %b required 01", req_ready);
        end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_fault_wrap();
        test_flush_mid();
        test_flush_completion();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ptw_multi.md
# ptw_multi

Parametrised multi-channel page-table-walker test stub for the TLB subsystem. Accepts translation requests from `NUM_CH` TLBs (channel 0 = ITLB, channel 1 = DTLB by convention) and arbitrates between them round-robin. Each accepted request gets a single-pulse response after a fixed, parameterised latency, carrying the PPN and an optional page-fault flag. Supports flush-abort of an in-flight walk. The translation is a deterministic test mapping, not a real memory walk.

## Interface
- `NUM_CH`, 2: number of requesting channels, ≥1.
- `VA_WIDTH`, 32: virtual address width.
- `PAGE_BITS`, 12: page offset bits; VPN = `va[VA_WIDTH-1:PAGE_BITS]`.
- `PPN_WIDTH`, 20: physical page number width.
- `LATENCY`, 8: cycles from accept to response, ≥1.
- `PPN_OFFSET`, 4: test mapping constant added to the VPN.
- `VPN_LIMIT`, 20'h80000: first faulting VPN (used only with `PTW_FAULT_EN`).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in NUM_CH: per-channel request.
- `req_ready` out NUM_CH: per-channel accept, one-hot or zero.
- `req_va` in NUM_CH*VA_WIDTH: per-channel VA, channel i at `[i*VA_WIDTH +: VA_WIDTH]`.
- `flush` in 1: abort the in-flight walk and block new accepts.
- `resp_valid` out NUM_CH: one-hot, 1-cycle response pulse to the owning channel.
- `resp_ppn` out PPN_WIDTH: translated PPN, shared by all channels.
- `resp_fault` out 1: page fault flag, shared by all channels.
- `busy` out 1: high while a walk is in progress.

## Operation
- FSM states: IDLE and WALK. Reset state is IDLE.
- Round-robin pointer `ptr` resets to 0.
- **IDLE, arbitration:** with `flush` low, grant the first channel i with `req_valid[i]` high, searching from `ptr` upward with wrap. `req_ready[i]` is combinational and asserted only for the granted channel, only in IDLE, only when `flush` is low.
- **Accept** (`req_valid & req_ready` at a rising edge):
  - latch VA and channel id;
  - load `cnt = LATENCY-1`;
  - set `ptr` to grant+1 mod NUM_CH;
  - go to WALK.
- **WALK:** if `cnt != 0`, decrement `cnt`. If `cnt == 0`, return to IDLE and register the response:
  - `resp_valid[ch]` = 1;
  - `resp_ppn` = (VPN zero-extended or truncated to PPN_WIDTH) + PPN_OFFSET, modulo 2^PPN_WIDTH;
  - `resp_fault` is set per the Configuration section.
- `resp_ppn` and `resp_fault` hold their last values after the pulse. `resp_valid` defaults to 0.
- **Flush in WALK:** go to IDLE and drop the response. Flush wins over a `cnt == 0` completion on the same edge.
- **Flush in IDLE:** no accepts; `ptr` is unchanged.
- **Requester rules:** a requester keeps `req_valid` and `req_va` stable until accepted. Dropping `req_valid` before accept is legal; that request is simply never serviced.

## Timing
- Reset values:
  - `req_ready` = 0;
  - `resp_valid` = 0;
  - `resp_ppn` = 0;
  - `resp_fault` = 0;
  - `busy` = 0;
  - `cnt` = 0;
  - `ptr` = 0.
- Reset mid-walk discards the walk. No response is emitted after reset deasserts.
- Latency: accept at edge E0 gives `resp_valid` high in the cycle after edge E0+LATENCY, for exactly 1 cycle.
- `busy` is high from the cycle after E0 through the cycle ending at E0+LATENCY.
- Back-to-back: the FSM is in IDLE during the `resp_valid` cycle, so `req_ready` may assert in that same cycle. Throughput is one walk per LATENCY+1 cycles.
- All outputs are registered except `req_ready`.

## Configuration
- `PTW_FAULT_EN` defined:
  - VPN ≥ VPN_LIMIT sets `resp_fault` = 1 and `resp_ppn` = 0;
  - otherwise `resp_fault` = 0 and `resp_ppn` follows the mapping.
- `PTW_FAULT_EN` undefined: fault logic is not compiled, `resp_fault` is tied 0, and every VPN maps.

## Test plan
- **Single request:** ch0, va 0x0001_2345, LATENCY 8, accept at E0. Expect `resp_valid` = 2'b01 only in the cycle after E0+8, `resp_ppn` = 0x00016, `resp_fault` = 0, and `resp_valid` low in all other cycles.
- **Arbitration:** both channels request right after reset (ch0 va 0x0000_1000, ch1 va 0x0000_2000). Expect:
  - ch0 granted first, response `resp_ppn` = 0x00005;
  - `req_ready[1]` high in the ch0 response cycle;
  - ch1 response `resp_ppn` = 0x00006 exactly 9 cycles after the ch0 response.
- **Fault and wrap:**
  - `PTW_FAULT_EN` on, ch1 va 0x8000_0000: expect `resp_fault` = 1, `resp_ppn` = 0.
  - `PTW_FAULT_EN` off, va 0xFFFF_F000: expect `resp_ppn` = 0x00003 (wrap), `resp_fault` = 0.
- **Flush mid-walk:** flush for 1 cycle, 3 cycles after accept. Expect `busy` → 0, no `resp_valid` ever for that request, and a new request accepted the cycle after `flush` falls.
- **Flush vs completion:** flush asserted on the completion edge. Expect no response and FSM in IDLE.
- **Reset mid-walk:** assert `rst` 4 cycles after accept. Expect all outputs 0 immediately, no response after release, and `ptr` = 0 (ch0 wins the next tie).
